// File: rtl/compr_pkg.sv
// Shared types and helpers for the chunked magnitude-compare sequencer.
// Provides the sequencer state enum, one-hot result encodings {gt,eq,lt},
// and sizing helpers for chunk count, chunk index and compare-count widths.
package compr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned RES_W = 3;

    // One-hot result encodings, bit order {gt, eq, lt}
    localparam logic [RES_W-1:0] RES_NONE = 3'b000;
    localparam logic [RES_W-1:0] RES_GT   = 3'b100;
    localparam logic [RES_W-1:0] RES_EQ   = 3'b010;
    localparam logic [RES_W-1:0] RES_LT   = 3'b001;

    function automatic int unsigned nchunk_f(input int unsigned width, input int unsigned chunk);
        return width / chunk;
    endfunction

    // Compare count must reach NCHUNK itself, hence the extra bit
    function automatic int unsigned cnt_w_f(input int unsigned nchunk);
        return $clog2(nchunk) + 1;
    endfunction

    // Chunk index width; kept at least one bit so NCHUNK = 1 still has a register
    function automatic int unsigned idx_w_f(input int unsigned nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/compr_chunk.sv
// Combinational CHUNK-bit unsigned comparator shared by all chunk steps.
// Ports:
//   a_i, b_i         CHUNK-bit slices to compare
//   gt_c_o/eq_c_o/lt_c_o  one-hot compare result (combinational)
module compr_chunk #(
    parameter int unsigned CHUNK = 2
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    output logic             gt_c_o,
    output logic             eq_c_o,
    output logic             lt_c_o
);

    always_comb begin
        gt_c_o = (a_i > b_i);
        eq_c_o = (a_i == b_i);
        lt_c_o = (a_i < b_i);
    end

endmodule

// File: rtl/compr_seq_ctrl.sv
// Wide unsigned magnitude compare walked MSB chunk first through one shared
// chunk comparator, with optional early exit on the first unequal chunk.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   start, a, b     compare request; operands latched when start is accepted
//   busy            high while chunks are being compared
//   done            one-cycle pulse when gt/eq/lt/ncmp become valid
//   gt, eq, lt      registered one-hot result, held until the next accepted start
//   ncmp            chunk compares used by the last operation
module compr_seq_ctrl
    import compr_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned CHUNK      = 2,
    parameter bit          EARLY_EXIT = 1'b1,
    localparam int unsigned NCHUNK    = nchunk_f(WIDTH, CHUNK),
    localparam int unsigned CNT_W     = cnt_w_f(NCHUNK)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [CNT_W-1:0] ncmp
);

    localparam int unsigned IDX_W = idx_w_f(NCHUNK);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   ncmp_q, ncmp_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic [RES_W-1:0]   mis_q, mis_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [CHUNK-1:0]   a_sl_c, b_sl_c;
    logic               cgt_c, ceq_c, clt_c;
    logic [RES_W-1:0]   chunk_res_c;

    // Select the chunk currently addressed by idx
    always_comb begin
        a_sl_c = a_q[idx_q*CHUNK +: CHUNK];
        b_sl_c = b_q[idx_q*CHUNK +: CHUNK];
    end

    compr_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_i    (a_sl_c),
        .b_i    (b_sl_c),
        .gt_c_o (cgt_c),
        .eq_c_o (ceq_c),
        .lt_c_o (clt_c)
    );

    assign chunk_res_c = {cgt_c, ceq_c, clt_c};

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        ncmp_d  = ncmp_q;
        res_d   = res_q;
        mis_d   = mis_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IDX_W'(NCHUNK - 1);
                    ncmp_d  = '0;
                    res_d   = RES_NONE;
                    mis_d   = RES_NONE;
                    state_d = RUN;
                end
            end
            RUN: begin
                ncmp_d = ncmp_q + CNT_W'(1);
                if (!ceq_c && EARLY_EXIT) begin
                    res_d   = chunk_res_c;
                    state_d = DONE;
                end else begin
                    // Only the most significant mismatch decides the result
                    if (!ceq_c && (mis_q == RES_NONE)) begin
                        mis_d = chunk_res_c;
                    end
                    if (idx_q == '0) begin
                        res_d   = (mis_d == RES_NONE) ? RES_EQ : mis_d;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            ncmp_q  <= '0;
            res_q   <= RES_NONE;
            mis_q   <= RES_NONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            ncmp_q  <= ncmp_d;
            res_q   <= res_d;
            mis_q   <= mis_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign gt   = res_q[2];
    assign eq   = res_q[1];
    assign lt   = res_q[0];
    assign ncmp = ncmp_q;

endmodule

// File: tb/tb_compr_seq_ctrl.sv
// Scoreboard bench for compr_seq_ctrl: two instances (early exit on / off)
// share stimulus; a reference model predicts result, compare count and done
// cycle per accepted start, and a negedge monitor checks every cycle.
module tb_compr_seq_ctrl;

    localparam int unsigned W   = 8;
    localparam int unsigned C   = 2;
    localparam int unsigned NCH = W / C;

    typedef struct {
        logic [2:0] res;
        int         ncmp;
        int         dc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;

    logic         busy_w [2];
    logic         done_w [2];
    logic         gt_w   [2];
    logic         eq_w   [2];
    logic         lt_w   [2];
    logic [2:0]   ncmp_w [2];

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    exp_t       sbq0[$];
    exp_t       sbq1[$];
    int         last_start [2] = '{-10, -10};
    int         last_done  [2] = '{-10, -10};
    logic [2:0] last_res   [2] = '{3'b000, 3'b000};
    int         last_ncmp  [2] = '{0, 0};

    compr_seq_ctrl #(.WIDTH(W), .CHUNK(C), .EARLY_EXIT(1'b1)) u_dut_ee (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy_w[0]), .done(done_w[0]), .gt(gt_w[0]), .eq(eq_w[0]),
        .lt(lt_w[0]), .ncmp(ncmp_w[0])
    );

    compr_seq_ctrl #(.WIDTH(W), .CHUNK(C), .EARLY_EXIT(1'b0)) u_dut_full (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy_w[1]), .done(done_w[1]), .gt(gt_w[1]), .eq(eq_w[1]),
        .lt(lt_w[1]), .ncmp(ncmp_w[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, d, cyc, act, expv);
        end
    endtask

    // Reference: result from plain unsigned compare; compares used from the
    // position of the most significant differing bit.
    function automatic exp_t ref_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                                    input bit ee, input int t);
        exp_t         e;
        int           p;
        logic [W-1:0] x;
        if (av > bv)       e.res = 3'b100;
        else if (av == bv) e.res = 3'b010;
        else               e.res = 3'b001;
        x = av ^ bv;
        p = 0;
        for (int i = 0; i < int'(W); i++) if (x[i]) p = i;
        if (!ee || av == bv) e.ncmp = NCH;
        else                 e.ncmp = NCH - p / C;
        e.dc = t + 1 + e.ncmp;
        return e;
    endfunction

    task automatic accept(input int d, input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        e = ref_op(av, bv, (d == 0), cyc);
        if (d == 0) sbq0.push_back(e);
        else        sbq1.push_back(e);
        last_start[d] = cyc;
        last_done[d]  = e.dc;
    endtask

    // One cycle of stimulus; a start is accepted when the DUT is idle or in its done cycle
    task automatic drive(input bit s, input logic [W-1:0] av, input logic [W-1:0] bv);
        @(posedge clk);
        #1;
        start = s;
        a     = av;
        b     = bv;
        if (s) begin
            for (int d = 0; d < 2; d++) begin
                if (cyc >= last_done[d]) accept(d, av, bv);
            end
        end
    endtask

    task automatic wait_free();
        while ((cyc + 1 <= last_done[0]) || (cyc + 1 <= last_done[1]))
            drive(1'b0, W'($urandom), W'($urandom));
    endtask

    task automatic model_reset();
        sbq0.delete();
        sbq1.delete();
        for (int d = 0; d < 2; d++) begin
            last_start[d] = -10;
            last_done[d]  = -10;
            last_res[d]   = 3'b000;
            last_ncmp[d]  = 0;
        end
    endtask

    task automatic chk_zero(input string nm);
        for (int d = 0; d < 2; d++) begin
            chk({nm, "_busy"}, d, 32'(busy_w[d]), 32'd0);
            chk({nm, "_done"}, d, 32'(done_w[d]), 32'd0);
            chk({nm, "_res"},  d, 32'({gt_w[d], eq_w[d], lt_w[d]}), 32'd0);
            chk({nm, "_ncmp"}, d, 32'(ncmp_w[d]), 32'd0);
        end
    endtask

    // Monitor: pops expected entry on its done cycle and checks all outputs each cycle
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            exp_t h;
            bit   due;
            bit   inrun;
            int   sz;
            due = 1'b0;
            sz  = (d == 0) ? sbq0.size() : sbq1.size();
            if (sz > 0) begin
                h   = (d == 0) ? sbq0[0] : sbq1[0];
                due = (h.dc == cyc);
            end
            chk("done", d, 32'(done_w[d]), 32'(due));
            if (due) begin
                if (d == 0) void'(sbq0.pop_front());
                else        void'(sbq1.pop_front());
                last_res[d]  = h.res;
                last_ncmp[d] = h.ncmp;
            end
            inrun = (cyc > last_start[d]) && (cyc < last_done[d]);
            chk("busy", d, 32'(busy_w[d]), 32'(inrun));
            chk("result", d, 32'({gt_w[d], eq_w[d], lt_w[d]}),
                32'(inrun ? 3'b000 : last_res[d]));
            chk("ncmp", d, 32'(ncmp_w[d]),
                inrun ? 32'(cyc - last_start[d] - 1) : 32'(last_ncmp[d]));
        end
    end

    initial begin
        logic [W-1:0] av, bv;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Full match, then an ignored start two cycles in with new operands
        wait_free();
        drive(1'b1, 8'hA5, 8'hA5);
        drive(1'b0, 8'h00, 8'h00);
        drive(1'b1, 8'h3C, 8'hC3);
        wait_free();

        // Top-chunk decision, second-chunk decision, LSB-chunk decision
        drive(1'b1, 8'hC0, 8'h3F);
        wait_free();
        drive(1'b1, 8'hA5, 8'hB5);
        wait_free();
        drive(1'b1, 8'hA4, 8'hA5);

        // Back-to-back start in the early-exit instance's done cycle
        while (cyc + 1 < last_done[0]) drive(1'b0, 8'h00, 8'h00);
        drive(1'b1, 8'h01, 8'h00);
        wait_free();

        // Asynchronous reset two cycles into a compare
        drive(1'b1, 8'hA5, 8'hA5);
        drive(1'b0, 8'h00, 8'h00);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("midrun_reset");
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        drive(1'b1, 8'h5A, 8'h59);
        wait_free();

        // Randomized traffic biased toward equal and near-equal operands
        for (int i = 0; i < 400; i++) begin
            av = W'($urandom);
            case ($urandom_range(0, 2))
                0:       bv = av;
                1:       bv = av ^ W'(1 << $urandom_range(0, 7));
                default: bv = W'($urandom);
            endcase
            drive($urandom_range(0, 1) == 1, av, bv);
        end
        wait_free();
        drive(1'b0, 8'h00, 8'h00);
        drive(1'b0, 8'h00, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
